// File: rtl/int_freqdiv_monitor_pkg.sv
// Shared definitions for the integer clock divider family: the
// counter-width helper, the monitor state encoding and the duty-window test.
// The file carries the package freq_div_pkg so the divider and the monitor
// can share one width function.
package freq_div_pkg;

  // Monitor FSM encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  // Bits needed to hold the values 0 .. value-1 (minimum 1 bit)
  function automatic int int_log2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    if (w == 0) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // A high phase is acceptable when it is either half of an odd or even period
  function automatic logic duty_in_window(input int div, input int high);
    return (high == (div / 32'sd2)) || (high == ((div + 32'sd1) / 32'sd2));
  endfunction

endpackage

// File: rtl/int_freqdiv_monitor_if.sv
// Signal bundle between the monitor and its consumer. The consumer (master)
// drives the enable and the divided clock; the monitor (slave) reports the
// measured period, the high phase and the health flags.
interface int_freqdiv_monitor_if #(
  parameter int CNT_W = 8
);
  logic             sync;
  logic             clk_div;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [CNT_W-1:0] high_time;
  logic             locked;
  logic             err;
  logic             timeout;

  modport master (
    output sync,
    output clk_div,
    input  period,
    input  period_valid,
    input  high_time,
    input  locked,
    input  err,
    input  timeout
  );

  modport slave (
    input  sync,
    input  clk_div,
    output period,
    output period_valid,
    output high_time,
    output locked,
    output err,
    output timeout
  );
endinterface

// File: rtl/int_freqdiv_monitor_sync2.sv
// Two-flop synchronizer bringing the monitored divided clock into the
// clk_in domain. Both flops clear on reset and on the synchronous clear.
module freqdiv_sync2 (
  input  logic clk_in,
  input  logic rst,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else if (i_clr) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/int_freqdiv_monitor.sv
// Receive-side checker for an integer-divided clock. Measures the period of
// clk_div in clk_in cycles, locks after LOCK_CNT consecutive periods equal to
// DIV, pulses err on a mismatch while locked and raises timeout when clk_div
// stops toggling for MAX_PERIOD cycles.
// Optional feature macro: INT_FREQDIV_DUTY_CHECK_EN adds high-phase
// measurement and a duty-cycle check while locked; without it high_time is 0.
module int_freqdiv_monitor
  import freq_div_pkg::*;
#(
  parameter int DIV        = 2,
  parameter int LOCK_CNT   = 4,
  parameter int MAX_PERIOD = 255
) (
  input logic                  clk_in,
  input logic                  rst,
  int_freqdiv_monitor_if.slave bus
);

  localparam int CNT_W = int_log2(MAX_PERIOD + 1);
  localparam int MC_W  = int_log2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] C_DIV     = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] C_MAX     = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(32'd1);
  localparam logic [MC_W-1:0]  C_LOCK    = MC_W'(LOCK_CNT);
  localparam logic [MC_W-1:0]  C_LOCK_M1 = MC_W'(LOCK_CNT - 1);
  localparam logic [MC_W-1:0]  C_MC_ONE  = MC_W'(32'd1);

  logic             w_clr;
  logic             w_s2;
  logic             r_s3;
  logic             r_rise;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [MC_W-1:0]  r_match_cnt;
  logic [MC_W-1:0]  w_match_nxt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_nxt;
  logic             r_period_valid;
  logic             w_pv_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             r_locked;
  logic             w_locked_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;

  logic             w_period_match;
  logic             w_cnt_at_max;
  logic             w_duty_bad;

  // sync low acts as a synchronous clear of the whole monitor
  assign w_clr = ~bus.sync;

  freqdiv_sync2 u_sync2 (
    .clk_in (clk_in),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_d    (bus.clk_div),
    .o_q    (w_s2)
  );

  // Delay stage and registered rising-edge pulse of the synchronized clock
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
    end else if (w_clr) begin
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s3   <= w_s2;
      r_rise <= w_s2 & ~r_s3;
    end
  end

`ifdef INT_FREQDIV_DUTY_CHECK_EN
  logic             r_fall;
  logic [CNT_W-1:0] r_high_time;

  // Registered falling-edge pulse and high-phase capture
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_fall      <= 1'b0;
      r_high_time <= {CNT_W{1'b0}};
    end else if (w_clr) begin
      r_fall      <= 1'b0;
      r_high_time <= {CNT_W{1'b0}};
    end else begin
      r_fall <= ~w_s2 & r_s3;
      if (r_fall) begin
        r_high_time <= r_cnt;
      end else begin
        r_high_time <= r_high_time;
      end
    end
  end

  assign w_duty_bad    = r_fall & ~duty_in_window(DIV, int'(r_cnt));
  assign bus.high_time = r_high_time;
`else
  assign w_duty_bad    = 1'b0;
  assign bus.high_time = {CNT_W{1'b0}};
`endif

  assign w_period_match = (r_cnt == C_DIV);
  assign w_cnt_at_max   = (r_cnt == C_MAX);

  // State, counter and output registers
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= {CNT_W{1'b0}};
      r_match_cnt    <= {MC_W{1'b0}};
      r_period       <= {CNT_W{1'b0}};
      r_period_valid <= 1'b0;
      r_err          <= 1'b0;
      r_locked       <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_match_cnt    <= w_match_nxt;
      r_period       <= w_period_nxt;
      r_period_valid <= w_pv_nxt;
      r_err          <= w_err_nxt;
      r_locked       <= w_locked_nxt;
      r_timeout      <= w_timeout_nxt;
    end
  end

  // Next-state and next-output decode of the measurement FSM
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_match_nxt   = r_match_cnt;
    w_period_nxt  = r_period;
    w_pv_nxt      = 1'b0;
    w_err_nxt     = 1'b0;
    w_locked_nxt  = r_locked;
    w_timeout_nxt = r_timeout;

    if (w_clr) begin
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = {CNT_W{1'b0}};
      w_match_nxt   = {MC_W{1'b0}};
      w_period_nxt  = {CNT_W{1'b0}};
      w_locked_nxt  = 1'b0;
      w_timeout_nxt = 1'b0;
    end else begin
      // Cycles since the last rising edge, saturating at the timeout limit
      if (r_rise) begin
        w_cnt_nxt = C_ONE;
      end else if (w_cnt_at_max) begin
        w_cnt_nxt = C_MAX;
      end else begin
        w_cnt_nxt = r_cnt + C_ONE;
      end

      case (r_state)
        S_IDLE: begin
          // First edge only opens the measurement window; its period is partial
          if (r_rise) begin
            w_state_nxt   = S_ACQ;
            w_timeout_nxt = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end

        S_ACQ: begin
          if (r_rise) begin
            w_period_nxt  = r_cnt;
            w_pv_nxt      = 1'b1;
            w_timeout_nxt = 1'b0;
            if (w_period_match) begin
              if (r_match_cnt == C_LOCK_M1) begin
                w_match_nxt  = C_LOCK;
                w_locked_nxt = 1'b1;
                w_state_nxt  = S_LOCK;
              end else begin
                w_match_nxt = r_match_cnt + C_MC_ONE;
              end
            end else begin
              w_match_nxt = {MC_W{1'b0}};
            end
          end else if (w_cnt_at_max) begin
            w_timeout_nxt = 1'b1;
            w_locked_nxt  = 1'b0;
            w_match_nxt   = {MC_W{1'b0}};
            w_state_nxt   = S_IDLE;
          end else begin
            w_state_nxt = S_ACQ;
          end
        end

        S_LOCK: begin
          if (r_rise) begin
            w_period_nxt  = r_cnt;
            w_pv_nxt      = 1'b1;
            w_timeout_nxt = 1'b0;
            if (!w_period_match) begin
              w_err_nxt    = 1'b1;
              w_locked_nxt = 1'b0;
              w_match_nxt  = {MC_W{1'b0}};
              w_state_nxt  = S_ACQ;
            end else begin
              w_state_nxt = S_LOCK;
            end
          end else if (w_cnt_at_max) begin
            w_timeout_nxt = 1'b1;
            w_locked_nxt  = 1'b0;
            w_match_nxt   = {MC_W{1'b0}};
            w_state_nxt   = S_IDLE;
          end else if (w_duty_bad) begin
            w_err_nxt    = 1'b1;
            w_locked_nxt = 1'b0;
            w_match_nxt  = {MC_W{1'b0}};
            w_state_nxt  = S_ACQ;
          end else begin
            w_state_nxt = S_LOCK;
          end
        end

        default: begin
          w_state_nxt  = S_IDLE;
          w_match_nxt  = {MC_W{1'b0}};
          w_locked_nxt = 1'b0;
        end
      endcase
    end
  end

  assign bus.period       = r_period;
  assign bus.period_valid = r_period_valid;
  assign bus.locked       = r_locked;
  assign bus.err          = r_err;
  assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_int_freqdiv_monitor.sv
// Self-checking bench for int_freqdiv_monitor (DIV=4, LOCK_CNT=4,
// MAX_PERIOD=15). The reference model works on rising/falling-edge
// timestamps of the driven clk_div, shifted by the monitor's fixed
// three-edge observation delay.
module tb_int_freqdiv_monitor;
  import freq_div_pkg::*;

  localparam int DIV   = 4;
  localparam int LOCK  = 4;
  localparam int MAXP  = 15;
  localparam int CNT_W = int_log2(MAXP + 1);
`ifdef INT_FREQDIV_DUTY_CHECK_EN
  localparam bit DUTY_ON = 1'b1;
`else
  localparam bit DUTY_ON = 1'b0;
`endif

  logic clk_in;
  logic rst;

  int_freqdiv_monitor_if #(.CNT_W(CNT_W)) bus_if ();

  int_freqdiv_monitor #(
    .DIV        (DIV),
    .LOCK_CNT   (LOCK),
    .MAX_PERIOD (MAXP)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus_if.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_tests;
  int n_fail;
  int t;
  logic eff [0:4095];

  // reference model state
  bit m_started;
  bit m_locked;
  int m_streak;
  int last_rise;
  int exp_period, exp_pv, exp_err, exp_timeout, exp_high;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp_v, t);
    end
  endtask

  // One clk_in edge of the reference model
  task automatic model_edge(input bit clr);
    bit rise, fall, tmo;
    int age;
    if (clr) begin
      for (int k = 0; k < 4; k++) eff[t-k] = 1'b0;
      m_started = 1'b0; m_locked = 1'b0; m_streak = 0;
      exp_period = 0; exp_pv = 0; exp_err = 0; exp_timeout = 0; exp_high = 0;
      last_rise = t + 1;
      return;
    end
    rise = eff[t-3] && !eff[t-4];
    fall = !eff[t-3] && eff[t-4];
    age  = t - last_rise;
    if (age > MAXP) age = MAXP;
    exp_pv = 0; exp_err = 0; tmo = 1'b0;
    if (DUTY_ON && fall) exp_high = age;
    if (rise) begin
      last_rise = t;
      exp_timeout = 0;
      if (!m_started) begin
        m_started = 1'b1;
      end else begin
        exp_period = age;
        exp_pv = 1;
        if (m_locked) begin
          if (age != DIV) begin exp_err = 1; m_locked = 1'b0; m_streak = 0; end
        end else if (age == DIV) begin
          m_streak++;
          if (m_streak == LOCK) m_locked = 1'b1;
        end else begin
          m_streak = 0;
        end
      end
    end else if (m_started && age == MAXP) begin
      tmo = 1'b1;
      exp_timeout = 1; m_locked = 1'b0; m_streak = 0; m_started = 1'b0;
    end
    if (DUTY_ON && !rise && !tmo && fall && m_locked &&
        !(age == DIV / 2 || age == (DIV + 1) / 2)) begin
      exp_err = 1; m_locked = 1'b0; m_streak = 0;
    end
  endtask

  task automatic check_outputs();
    chk("period",       32'(bus_if.period),       32'(exp_period));
    chk("period_valid", 32'(bus_if.period_valid), 32'(exp_pv));
    chk("err",          32'(bus_if.err),          32'(exp_err));
    chk("locked",       32'(bus_if.locked),       32'(m_locked));
    chk("timeout",      32'(bus_if.timeout),      32'(exp_timeout));
    chk("high_time",    32'(bus_if.high_time),    32'(exp_high));
  endtask

  task automatic cyc(input logic dv);
    @(negedge clk_in);
    bus_if.clk_div = dv;
    eff[t] = dv;
    @(posedge clk_in);
    model_edge(!rst || !bus_if.sync);
    #1;
    check_outputs();
    t++;
  endtask

  task automatic per(input int hi, input int lo);
    repeat (hi) cyc(1'b1);
    repeat (lo) cyc(1'b0);
  endtask

  initial begin
    int r, hi, lo;
    n_tests = 0; n_fail = 0; t = 4;
    for (int i = 0; i < 4096; i++) eff[i] = 1'b0;
    rst = 1'b0; bus_if.sync = 1'b1; bus_if.clk_div = 1'b0;

    // reset state
    repeat (3) cyc(1'b0);
    rst = 1'b1;

    // divide-by-4 input: acquire and lock
    repeat (8) per(2, 2);
    chk("s1_locked", 32'(bus_if.locked), 32'd1);

    // one long period of 5, then re-lock
    per(3, 2);
    repeat (6) per(2, 2);
    chk("s2_relocked", 32'(bus_if.locked), 32'd1);

    // period equal to the timeout limit: rise wins, counted as mismatch
    per(1, 14);
    repeat (6) per(2, 2);

    // stalled clk_div while locked
    repeat (25) cyc(1'b0);
    chk("s3_timeout", 32'(bus_if.timeout), 32'd1);
    chk("s3_unlocked", 32'(bus_if.locked), 32'd0);
    repeat (7) per(2, 2);
    chk("s3_timeout_cleared", 32'(bus_if.timeout), 32'd0);

    // sync dropped for one cycle while locked
    bus_if.sync = 1'b0;
    cyc(1'b0);
    chk("s4_sync_unlock", 32'(bus_if.locked), 32'd0);
    bus_if.sync = 1'b1;
    repeat (7) per(2, 2);

    // asynchronous reset in the middle of a period
    per(2, 2);
    cyc(1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("s5_async_locked",  32'(bus_if.locked),       32'd0);
    chk("s5_async_timeout", 32'(bus_if.timeout),      32'd0);
    chk("s5_async_period",  32'(bus_if.period),       32'd0);
    chk("s5_async_pv",      32'(bus_if.period_valid), 32'd0);
    repeat (2) cyc(1'b0);
    rst = 1'b1;
    repeat (8) per(2, 2);
    chk("s5_recovered", 32'(bus_if.locked), 32'd1);

    // skewed duty cycle with a correct period
    repeat (3) per(3, 1);
    chk("s6_duty_locked", 32'(bus_if.locked), DUTY_ON ? 32'd0 : 32'd1);

    // randomized periods, duty cycles, stalls and sync drops
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        hi = 2; lo = 2;
      end else if (r < 8) begin
        hi = $urandom_range(1, 3); lo = $urandom_range(1, 4);
      end else if (r == 8) begin
        hi = $urandom_range(1, 2); lo = $urandom_range(10, 18);
      end else begin
        hi = $urandom_range(1, 4); lo = $urandom_range(1, 2);
      end
      if ($urandom_range(0, 29) == 0) begin
        bus_if.sync = 1'b0;
        cyc(1'b0);
        bus_if.sync = 1'b1;
      end
      per(hi, lo);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
